line_raster: RTL and testbench

//  Read side of the line register queue. Pops one line (start/end/colour) at a

---
 rtl/line_raster_if.sv | 35 +++
 rtl/line_raster.sv | 191 +++++++++++++++++++
 tb/tb_line_raster.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_raster_if.sv
// line_raster_if: groups the signals between the line queue, the rasteriser
// and the framebuffer write port.
//   Queue head : QStartX/QStartY/QEndX/QEndY (11b two's complement), QColor (3b),
//                empty, read (pop strobe)
//   Pixel port : pixX (10b), pixY (9b), pixColor (3b), pixValid, pixReady
//   Status     : busy, lineDone
// Modports:
//   master - the rasteriser (drives read, pixel bus and status)
//   slave  - the environment (queue and framebuffer side)
interface line_raster_if;
  logic [10:0] QStartX;
  logic [10:0] QStartY;
  logic [10:0] QEndX;
  logic [10:0] QEndY;
  logic [2:0]  QColor;
  logic        empty;
  logic        read;
  logic [9:0]  pixX;
  logic [8:0]  pixY;
  logic [2:0]  pixColor;
  logic        pixValid;
  logic        pixReady;
  logic        busy;
  logic        lineDone;

  modport master (
    input  QStartX, QStartY, QEndX, QEndY, QColor, empty, pixReady,
    output read, pixX, pixY, pixColor, pixValid, busy, lineDone
  );

  modport slave (
    output QStartX, QStartY, QEndX, QEndY, QColor, empty, pixReady,
    input  read, pixX, pixY, pixColor, pixValid, busy, lineDone
  );
endinterface

// File: rtl/line_raster.sv
// line_raster: pops one line (start, end, colour) from the line queue and
// rasterises it with Bresenham, emitting one framebuffer pixel write per step
// over a valid/ready handshake. Pixels falling outside the visible screen are
// dropped without stalling.
// Ports:
//   clk    - clock
//   rst_b  - asynchronous active-low reset; abandons any line in progress
//   lq     - line_raster_if.master: queue head + pop, pixel write port, status
module line_raster #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int X_ORIGIN = 320,
  parameter int Y_ORIGIN = 240
) (
  input  logic          clk,
  input  logic          rst_b,
  line_raster_if.master lq
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  state_t state_reg, state_next;

  logic signed [11:0] x0_reg, x0_next;
  logic signed [11:0] y0_reg, y0_next;
  logic signed [11:0] x1_reg, x1_next;
  logic signed [11:0] y1_reg, y1_next;
  logic signed [11:0] cur_x_reg, cur_x_next;
  logic signed [11:0] cur_y_reg, cur_y_next;
  logic [2:0]         col_reg, col_next;
  logic signed [13:0] dx_reg, dx_next;
  logic signed [13:0] dy_reg, dy_next;
  logic signed [13:0] err_reg, err_next;
  logic               sx_neg_reg, sx_neg_next;
  logic               sy_neg_reg, sy_neg_next;

  // Sign-extend the four queue coordinates to the 12-bit working width.
  logic [10:0]        q_coord [4];
  logic signed [11:0] q_ext   [4];

  assign q_coord[0] = lq.QStartX;
  assign q_coord[1] = lq.QStartY;
  assign q_coord[2] = lq.QEndX;
  assign q_coord[3] = lq.QEndY;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sext
      assign q_ext[gi] = $signed({q_coord[gi][10], q_coord[gi]});
    end
  endgenerate

  // Setup arithmetic: absolute deltas of the latched endpoints.
  logic signed [12:0] dx_diff, dy_diff;
  logic signed [13:0] dx_abs, dy_abs;

  assign dx_diff = 13'(x1_reg) - 13'(x0_reg);
  assign dy_diff = 13'(y1_reg) - 13'(y0_reg);
  assign dx_abs  = (dx_diff < 13'sd0) ? -14'(dx_diff) : 14'(dx_diff);
  assign dy_abs  = (dy_diff < 13'sd0) ? -14'(dy_diff) : 14'(dy_diff);

  // Vector space to screen space: +y in vector space is screen up.
  logic signed [12:0] scr_x, scr_y;
  logic               in_bounds;

  assign scr_x = 13'(cur_x_reg) + 13'(X_ORIGIN);
  assign scr_y = 13'(Y_ORIGIN) - 13'(cur_y_reg);
  assign in_bounds = (scr_x >= 13'sd0) && (scr_x < 13'(SCREEN_W)) &&
                     (scr_y >= 13'sd0) && (scr_y < 13'(SCREEN_H));

  // Bresenham step decision; both axis tests use the pre-step error.
  logic signed [14:0] e2;
  logic               step_x, step_y, at_end;
  logic signed [13:0] err_step;

  assign e2     = $signed({err_reg, 1'b0});
  assign step_x = (e2 >= 15'(dy_reg));
  assign step_y = (e2 <= 15'(dx_reg));
  assign at_end = (cur_x_reg == x1_reg) && (cur_y_reg == y1_reg);

  always_comb begin
    err_step = err_reg;
    if (step_x) err_step = err_step + dy_reg;
    if (step_y) err_step = err_step + dx_reg;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg  <= IDLE;
      x0_reg     <= '0;
      y0_reg     <= '0;
      x1_reg     <= '0;
      y1_reg     <= '0;
      cur_x_reg  <= '0;
      cur_y_reg  <= '0;
      col_reg    <= '0;
      dx_reg     <= '0;
      dy_reg     <= '0;
      err_reg    <= '0;
      sx_neg_reg <= 1'b0;
      sy_neg_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x0_reg     <= x0_next;
      y0_reg     <= y0_next;
      x1_reg     <= x1_next;
      y1_reg     <= y1_next;
      cur_x_reg  <= cur_x_next;
      cur_y_reg  <= cur_y_next;
      col_reg    <= col_next;
      dx_reg     <= dx_next;
      dy_reg     <= dy_next;
      err_reg    <= err_next;
      sx_neg_reg <= sx_neg_next;
      sy_neg_reg <= sy_neg_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x0_next     = x0_reg;
    y0_next     = y0_reg;
    x1_next     = x1_reg;
    y1_next     = y1_reg;
    cur_x_next  = cur_x_reg;
    cur_y_next  = cur_y_reg;
    col_next    = col_reg;
    dx_next     = dx_reg;
    dy_next     = dy_reg;
    err_next    = err_reg;
    sx_neg_next = sx_neg_reg;
    sy_neg_next = sy_neg_reg;

    lq.read     = 1'b0;
    lq.pixValid = 1'b0;
    lq.pixX     = '0;
    lq.pixY     = '0;
    lq.pixColor = '0;
    lq.busy     = (state_reg != IDLE);
    lq.lineDone = 1'b0;

    case (state_reg)
      IDLE: begin
        // rst_b gating keeps read low while reset is held with a non-empty queue.
        if (rst_b && !lq.empty) begin
          lq.read    = 1'b1;
          x0_next    = q_ext[0];
          y0_next    = q_ext[1];
          x1_next    = q_ext[2];
          y1_next    = q_ext[3];
          col_next   = lq.QColor;
          state_next = SETUP;
        end
      end

      SETUP: begin
        dx_next     = dx_abs;
        dy_next     = -dy_abs;
        err_next    = dx_abs - dy_abs;
        sx_neg_next = !(x0_reg < x1_reg);
        sy_neg_next = !(y0_reg < y1_reg);
        cur_x_next  = x0_reg;
        cur_y_next  = y0_reg;
        state_next  = DRAW;
      end

      DRAW: begin
        if (in_bounds) begin
          lq.pixValid = 1'b1;
          lq.pixX     = scr_x[9:0];
          lq.pixY     = scr_y[8:0];
          lq.pixColor = col_reg;
        end
        // Off-screen steps complete immediately; on-screen ones wait for ready.
        if (!in_bounds || lq.pixReady) begin
          if (at_end) begin
            lq.lineDone = 1'b1;
            state_next  = IDLE;
          end else begin
            err_next = err_step;
            if (step_x) cur_x_next = cur_x_reg + (sx_neg_reg ? -12'sd1 : 12'sd1);
            if (step_y) cur_y_next = cur_y_reg + (sy_neg_reg ? -12'sd1 : 12'sd1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_raster.sv
// tb_line_raster: directed tests of line_raster with hand-computed pixel lists.
// A small queue model feeds the queue-head inputs and pops on read; a monitor
// logs every accepted pixel, read strobe, dropped step and lineDone.
module tb_line_raster;
  logic clk = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  line_raster_if bus ();

  line_raster #(
    .SCREEN_W(640),
    .SCREEN_H(480),
    .X_ORIGIN(320),
    .Y_ORIGIN(240)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .lq   (bus)
  );

  // Line queue model
  logic [10:0] qsx [0:31];
  logic [10:0] qsy [0:31];
  logic [10:0] qex [0:31];
  logic [10:0] qey [0:31];
  logic [2:0]  qc  [0:31];
  int q_head = 0;
  int q_tail = 0;

  assign bus.QStartX = qsx[q_head[4:0]];
  assign bus.QStartY = qsy[q_head[4:0]];
  assign bus.QEndX   = qex[q_head[4:0]];
  assign bus.QEndY   = qey[q_head[4:0]];
  assign bus.QColor  = qc[q_head[4:0]];
  assign bus.empty   = (q_head == q_tail);

  always @(posedge clk) if (bus.read) q_head <= q_head + 1;

  // Monitor
  int cyc = 0;
  int acc_x[$], acc_y[$], acc_c[$], acc_cyc[$];
  int rd_cyc[$], done_cyc[$];
  int drop_cnt = 0;
  logic prev_read = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.read) rd_cyc.push_back(cyc);
    if (bus.pixValid && bus.pixReady) begin
      acc_x.push_back(int'(bus.pixX));
      acc_y.push_back(int'(bus.pixY));
      acc_c.push_back(int'(bus.pixColor));
      acc_cyc.push_back(cyc);
      $display("pixel x=%0d y=%0d col=%0d cyc=%0d", bus.pixX, bus.pixY, bus.pixColor, cyc);
    end
    // busy without a pixel is a dropped step, except for the SETUP cycle after read
    if (bus.busy && !bus.pixValid && !prev_read) drop_cnt++;
    if (bus.lineDone) begin
      done_cyc.push_back(cyc);
      $display("lineDone cyc=%0d", cyc);
    end
    prev_read = bus.read;
  end

  int total_cnt = 0;
  int bad_cnt = 0;
  int exp_x[$], exp_y[$], exp_c[$];

  task automatic chk(input string tag, input int got, input int exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_line(input int x0, input int y0, input int x1, input int y1, input int c);
    qsx[q_tail[4:0]] = 11'(x0);
    qsy[q_tail[4:0]] = 11'(y0);
    qex[q_tail[4:0]] = 11'(x1);
    qey[q_tail[4:0]] = 11'(y1);
    qc[q_tail[4:0]]  = 3'(c);
    q_tail++;
  endtask

  task automatic add_exp(input int x, input int y, input int c);
    exp_x.push_back(x);
    exp_y.push_back(y);
    exp_c.push_back(c);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cyc.size() < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cyc.size() < target) chk("done_timeout", done_cyc.size(), target);
    #1;
  endtask

  task automatic wait_pixels(input int target, input int budget);
    int n = 0;
    while (acc_x.size() < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (acc_x.size() < target) chk("pix_timeout", acc_x.size(), target);
  endtask

  task automatic chk_pixels(input string tag, input int base);
    chk({tag, "_count"}, acc_x.size() - base, exp_x.size());
    for (int i = 0; i < exp_x.size(); i++) begin
      if (base + i < acc_x.size()) begin
        chk($sformatf("%s_x%0d", tag, i), acc_x[base+i], exp_x[i]);
        chk($sformatf("%s_y%0d", tag, i), acc_y[base+i], exp_y[i]);
        chk($sformatf("%s_c%0d", tag, i), acc_c[base+i], exp_c[i]);
      end
    end
    exp_x.delete();
    exp_y.delete();
    exp_c.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, rb, db, d0, sz_r, rd_r;
    logic stable;
    logic [9:0] snap_x;
    logic [8:0] snap_y;
    logic [2:0] snap_c;
    logic snap_v;

    bus.pixReady = 1'b1;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read",     int'(bus.read), 0);
    chk("rst_pixValid", int'(bus.pixValid), 0);
    chk("rst_busy",     int'(bus.busy), 0);
    chk("rst_lineDone", int'(bus.lineDone), 0);
    chk("rst_pixX",     int'(bus.pixX), 0);
    chk("rst_pixY",     int'(bus.pixY), 0);
    chk("rst_pixColor", int'(bus.pixColor), 0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Horizontal line
    base = acc_x.size(); rb = rd_cyc.size(); db = done_cyc.size();
    push_line(0, 0, 3, 0, 5);
    wait_done(db + 1, 50);
    chk("horiz_busy_after", int'(bus.busy), 0);
    chk("horiz_reads", rd_cyc.size() - rb, 1);
    chk("horiz_latency",
        ((acc_cyc.size() > base && rd_cyc.size() > rb) ? acc_cyc[base] - rd_cyc[rb] : -1), 2);
    chk("horiz_done_with_last",
        ((acc_cyc.size() > base + 3 && done_cyc.size() > db) ? done_cyc[db] - acc_cyc[base+3] : -1), 0);
    add_exp(320, 240, 5); add_exp(321, 240, 5); add_exp(322, 240, 5); add_exp(323, 240, 5);
    chk_pixels("horiz", base);

    // Steep line
    base = acc_x.size(); db = done_cyc.size();
    push_line(0, 0, 1, 3, 2);
    wait_done(db + 1, 50);
    add_exp(320, 240, 2); add_exp(320, 239, 2); add_exp(321, 238, 2); add_exp(321, 237, 2);
    chk_pixels("steep", base);

    // Zero-length line
    base = acc_x.size(); db = done_cyc.size();
    push_line(10, -10, 10, -10, 7);
    wait_done(db + 1, 50);
    repeat (2) @(posedge clk);
    #1;
    chk("zero_dones", done_cyc.size() - db, 1);
    add_exp(330, 250, 7);
    chk_pixels("zero", base);

    // Backpressure mid-line
    base = acc_x.size(); db = done_cyc.size();
    push_line(0, 0, 5, 0, 6);
    wait_pixels(base + 2, 50);
    #1 bus.pixReady = 1'b0;
    #1;
    snap_v = bus.pixValid; snap_x = bus.pixX; snap_y = bus.pixY; snap_c = bus.pixColor;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.pixValid !== snap_v || bus.pixX !== snap_x ||
          bus.pixY !== snap_y || bus.pixColor !== snap_c) stable = 1'b0;
    end
    chk("bp_valid_held", int'(snap_v), 1);
    chk("bp_held_x", int'(snap_x), 322);
    chk("bp_stable", int'(stable), 1);
    @(posedge clk);
    #1 bus.pixReady = 1'b1;
    wait_done(db + 1, 50);
    for (int i = 0; i < 6; i++) add_exp(320 + i, 240, 6);
    chk_pixels("bp", base);

    // Clipped line: screen x -10..2
    base = acc_x.size(); db = done_cyc.size(); d0 = drop_cnt;
    push_line(-330, 0, -318, 0, 1);
    wait_done(db + 1, 60);
    repeat (3) @(posedge clk);
    #1;
    chk("clip_drops", drop_cnt - d0, 10);
    chk("clip_dones", done_cyc.size() - db, 1);
    add_exp(0, 240, 1); add_exp(1, 240, 1); add_exp(2, 240, 1);
    chk_pixels("clip", base);

    // Two lines queued back-to-back
    base = acc_x.size(); rb = rd_cyc.size(); db = done_cyc.size();
    push_line(0, 0, 1, 1, 4);
    push_line(-2, 0, -2, -2, 3);
    wait_done(db + 2, 80);
    chk("b2b_reads", rd_cyc.size() - rb, 2);
    chk("b2b_read_gap",
        ((rd_cyc.size() > rb + 1 && done_cyc.size() > db) ? rd_cyc[rb+1] - done_cyc[db] : -1), 1);
    add_exp(320, 240, 4); add_exp(321, 239, 4);
    add_exp(318, 240, 3); add_exp(318, 241, 3); add_exp(318, 242, 3);
    chk_pixels("b2b", base);

    // Reset during DRAW
    base = acc_x.size(); db = done_cyc.size();
    push_line(0, 0, 20, 0, 5);
    push_line(5, 5, 6, 5, 2);
    wait_pixels(base + 3, 50);
    #1 rst_b = 1'b0;
    #1;
    chk("rstd_pixValid", int'(bus.pixValid), 0);
    chk("rstd_busy",     int'(bus.busy), 0);
    chk("rstd_pixX",     int'(bus.pixX), 0);
    chk("rstd_read",     int'(bus.read), 0);
    chk("rstd_lineDone", int'(bus.lineDone), 0);
    sz_r = acc_x.size(); rd_r = rd_cyc.size();
    repeat (3) @(posedge clk);
    #1;
    chk("rstd_no_pixels", acc_x.size() - sz_r, 0);
    chk("rstd_no_reads", rd_cyc.size() - rd_r, 0);
    rst_b = 1'b1;
    wait_done(db + 1, 50);
    repeat (3) @(posedge clk);
    #1;
    chk("rstd_reads_after", rd_cyc.size() - rd_r, 1);
    chk("rstd_dones", done_cyc.size() - db, 1);
    add_exp(325, 235, 2); add_exp(326, 235, 2);
    chk_pixels("rstd", sz_r);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
